reorder_buffer_wr_burst: RTL and testbench

//  Parametrised write-response reorder buffer for the ECI write path. It tags each

---
 rtl/reorder_buffer_wr_burst_if.sv | 39 +++
 rtl/reorder_buffer_wr_burst.sv | 243 ++++++++++++++++++++++++
 tb/tb_reorder_buffer_wr_burst.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_wr_burst_if.sv
// Handshake bundle around the write-response reorder buffer.
// The s_* signals face the AXI write master and the m_* signals face the ECI
// write engine. The "slave" modport is the buffer's view. The "master" modport
// is the view of the environment that surrounds the buffer.
interface reorder_buffer_wr_burst_if #(
  parameter int ADDR_BITS = 40,
  parameter int ID_BITS   = 5
);
  logic [ADDR_BITS-1:0] s_awaddr;
  logic [7:0]           s_awlen;
  logic                 s_awvalid;
  logic                 s_awready;
  logic [1:0]           s_bresp;
  logic                 s_bvalid;
  logic                 s_bready;
  logic [ADDR_BITS-1:0] m_awaddr;
  logic [7:0]           m_awlen;
  logic [ID_BITS-1:0]   m_awid;
  logic                 m_awvalid;
  logic                 m_awready;
  logic [ID_BITS-1:0]   m_bid;
  logic [1:0]           m_bresp;
  logic                 m_bvalid;
  logic                 m_bready;

  modport slave (
    input  s_awaddr, s_awlen, s_awvalid, s_bready,
    input  m_awready, m_bid, m_bresp, m_bvalid,
    output s_awready, s_bresp, s_bvalid,
    output m_awaddr, m_awlen, m_awid, m_awvalid, m_bready
  );

  modport master (
    output s_awaddr, s_awlen, s_awvalid, s_bready,
    output m_awready, m_bid, m_bresp, m_bvalid,
    input  s_awready, s_bresp, s_bvalid,
    input  m_awaddr, m_awlen, m_awid, m_awvalid, m_bready
  );
endinterface

// File: rtl/reorder_buffer_wr_burst.sv
// Write-response reorder buffer for the ECI write path.
// Each upstream AW burst receives a contiguous ring of thread IDs, starting at
// the head pointer. Per-beat B responses come back in any order and are marked
// against their slots. Bursts retire in order from the tail pointer. Each
// retired burst produces one upstream B that carries the worst response seen
// across its beats.
module reorder_buffer_wr_burst #(
  parameter  int N_THREADS = 32,
  parameter  int MAX_BURST = 4,
  parameter  int ADDR_BITS = 40,
  parameter  int ID_BITS   = 5,
  localparam int OCC_BITS  = $clog2(N_THREADS + 1),
  localparam int LEN_BITS  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  reorder_buffer_wr_burst_if.slave  bus,
  output logic [OCC_BITS-1:0]       occupancy,
  output logic                      err_bid,
  output logic                      err_awlen
);

  // Per-slot state, gathered from the slot generate below.
  logic [N_THREADS-1:0] alloc_vec;
  logic [N_THREADS-1:0] done_vec;
  logic [1:0]           resp_vec [N_THREADS];
  logic [LEN_BITS-1:0]  len_vec  [N_THREADS];

  // Ring pointers and the registered upstream B channel.
  logic [ID_BITS-1:0]  head_reg;
  logic [ID_BITS-1:0]  tail_reg;
  logic [OCC_BITS-1:0] occ_reg;
  logic [OCC_BITS-1:0] occ_next;
  logic                bvalid_reg;
  logic [1:0]          bresp_reg;
  logic                err_bid_reg;
  logic                err_awlen_reg;

  // Issue side.
  logic                aw_legal;
  logic [LEN_BITS-1:0] aw_len;
  logic                head_free;
  logic [ID_BITS-1:0]  head_idx;
  logic [OCC_BITS:0]   occ_after;
  logic                occ_fits;
  logic                can_issue;
  logic                aw_fire;
  logic                aw_drop;

  // Retire side.
  logic [LEN_BITS-1:0] tail_len;
  logic [ID_BITS-1:0]  tail_idx;
  logic                tail_done;
  logic [1:0]          merged;
  logic [1:0]          beat_sev;
  logic                retire;
  logic [OCC_BITS-1:0] alloc_cnt;
  logic [OCC_BITS-1:0] free_cnt;

  // Downstream response side.
  logic b_slot_ok;
  logic b_accept;
  logic b_err;

  assign aw_legal = bus.s_awlen < 8'(MAX_BURST);
  assign aw_len   = bus.s_awlen[LEN_BITS-1:0];

  // Check that every slot the request would claim, starting at head, is free.
  always_comb begin
    head_free = 1'b1;
    head_idx  = '0;
    for (int k = 0; k < MAX_BURST; k++) begin
      head_idx = head_reg + ID_BITS'(k);
      if ((LEN_BITS'(k) <= aw_len) && alloc_vec[head_idx]) begin
        head_free = 1'b0;
      end
    end
  end

  // Issue decision. Only registered state feeds it, so a B arriving this
  // cycle can never reach s_awready combinationally.
  always_comb begin
    occ_after = {1'b0, occ_reg} + (OCC_BITS+1)'(aw_len) + (OCC_BITS+1)'(1);
    occ_fits  = occ_after <= (OCC_BITS+1)'(N_THREADS);
    can_issue = head_free & occ_fits;
    aw_fire   = bus.s_awvalid & bus.m_awready & can_issue & aw_legal;
    aw_drop   = bus.s_awvalid & ~aw_legal;
  end

  assign bus.m_awvalid = bus.s_awvalid & can_issue & aw_legal;
  assign bus.s_awready = (bus.m_awready & can_issue & aw_legal) | aw_drop;
  assign bus.m_awaddr  = bus.s_awaddr;
  assign bus.m_awlen   = bus.s_awlen;
  assign bus.m_awid    = head_reg;
  assign bus.m_bready  = 1'b1;

  // Classify the incoming per-beat response: accept it, or flag it as stray.
  always_comb begin
    b_slot_ok = alloc_vec[bus.m_bid] & ~done_vec[bus.m_bid];
    b_accept  = bus.m_bvalid & b_slot_ok;
    b_err     = bus.m_bvalid & ~b_slot_ok;
  end

  // Check completion of the oldest burst and fold its beat responses into
  // one worst-case code. EXOKAY counts as OKAY.
  always_comb begin
    tail_len  = len_vec[tail_reg];
    tail_done = 1'b1;
    merged    = 2'd0;
    tail_idx  = '0;
    beat_sev  = 2'd0;
    for (int k = 0; k < MAX_BURST; k++) begin
      tail_idx = tail_reg + ID_BITS'(k);
      beat_sev = (resp_vec[tail_idx] == 2'd1) ? 2'd0 : resp_vec[tail_idx];
      if (LEN_BITS'(k) <= tail_len) begin
        if (!done_vec[tail_idx]) begin
          tail_done = 1'b0;
        end
        if (beat_sev > merged) begin
          merged = beat_sev;
        end
      end
    end
    retire = (~bvalid_reg | bus.s_bready) & tail_done;
  end

  // Slot counts added and removed this cycle. Both can happen together.
  always_comb begin
    alloc_cnt = aw_fire ? (OCC_BITS'(aw_len) + OCC_BITS'(1)) : '0;
    free_cnt  = retire ? (OCC_BITS'(tail_len) + OCC_BITS'(1)) : '0;
    occ_next  = occ_reg + alloc_cnt - free_cnt;
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_THREADS; gi++) begin : g_slot
      logic [ID_BITS-1:0]  head_off;
      logic [ID_BITS-1:0]  tail_off;
      logic                set_alloc;
      logic                set_free;
      logic                set_done;
      logic                is_first;
      logic                alloc_reg;
      logic                done_reg;
      logic [1:0]          resp_reg;
      logic [LEN_BITS-1:0] len_reg;

      assign head_off  = ID_BITS'(gi) - head_reg;
      assign tail_off  = ID_BITS'(gi) - tail_reg;
      assign set_alloc = aw_fire && (head_off <= ID_BITS'(aw_len));
      assign is_first  = (head_off == '0);
      assign set_free  = retire && (tail_off <= ID_BITS'(tail_len));
      assign set_done  = b_accept && (bus.m_bid == ID_BITS'(gi));

      // Slot lifecycle: a free slot is allocated, marked done, and then freed.
      // A slot that is freed at a clock edge can be allocated again from the
      // next cycle.
      always_ff @(posedge aclk) begin
        if (!aresetn) begin
          alloc_reg <= 1'b0;
          done_reg  <= 1'b0;
          resp_reg  <= 2'd0;
          len_reg   <= '0;
        end else begin
          if (set_free) begin
            alloc_reg <= 1'b0;
          end else if (set_alloc) begin
            alloc_reg <= 1'b1;
          end
          if (set_free) begin
            done_reg <= 1'b0;
          end else if (set_done) begin
            done_reg <= 1'b1;
          end
          if (set_done) begin
            resp_reg <= bus.m_bresp;
          end
          if (set_alloc && is_first) begin
            len_reg <= aw_len;
          end
        end
      end

      assign alloc_vec[gi] = alloc_reg;
      assign done_vec[gi]  = done_reg;
      assign resp_vec[gi]  = resp_reg;
      assign len_vec[gi]   = len_reg;
    end
  endgenerate

  // Advance the ring pointers and the occupancy count.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      head_reg <= '0;
      tail_reg <= '0;
      occ_reg  <= '0;
    end else begin
      if (aw_fire) begin
        head_reg <= head_reg + ID_BITS'(aw_len) + ID_BITS'(1);
      end
      if (retire) begin
        tail_reg <= tail_reg + ID_BITS'(tail_len) + ID_BITS'(1);
      end
      occ_reg <= occ_next;
    end
  end

  // Upstream B register. It holds its value until accepted, and reloads in
  // the same cycle as the accept so that one B per cycle is sustained.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      bvalid_reg <= 1'b0;
      bresp_reg  <= 2'd0;
    end else if (retire) begin
      bvalid_reg <= 1'b1;
      bresp_reg  <= merged;
    end else if (bus.s_bready) begin
      bvalid_reg <= 1'b0;
    end
  end

  // Sticky error flags for stray responses and oversize bursts.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      err_bid_reg   <= 1'b0;
      err_awlen_reg <= 1'b0;
    end else begin
      if (b_err) begin
        err_bid_reg <= 1'b1;
      end
      if (aw_drop) begin
        err_awlen_reg <= 1'b1;
      end
    end
  end

  assign bus.s_bvalid = bvalid_reg;
  assign bus.s_bresp  = bresp_reg;
  assign occupancy    = occ_reg;
  assign err_bid      = err_bid_reg;
  assign err_awlen    = err_awlen_reg;

endmodule

// File: tb/tb_reorder_buffer_wr_burst.sv
// Bench for reorder_buffer_wr_burst. The bench plays both the AXI write
// master and the ECI write engine. Beat responses are chosen when a burst is
// issued downstream. At that point the burst's merged response is pushed into
// a scoreboard queue. A monitor pops the queue on every upstream B.
module tb_reorder_buffer_wr_burst;
  localparam int N_THREADS = 32;
  localparam int MAX_BURST = 4;
  localparam int ADDR_BITS = 40;
  localparam int ID_BITS   = 5;

  typedef struct {
    logic [ID_BITS-1:0] id;
    logic [1:0]         resp;
  } beat_t;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic [5:0] occupancy;
  logic       err_bid;
  logic       err_awlen;

  always #5 aclk = ~aclk;

  reorder_buffer_wr_burst_if #(.ADDR_BITS(ADDR_BITS), .ID_BITS(ID_BITS)) bus ();

  reorder_buffer_wr_burst #(
    .N_THREADS(N_THREADS), .MAX_BURST(MAX_BURST),
    .ADDR_BITS(ADDR_BITS), .ID_BITS(ID_BITS)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .bus(bus),
    .occupancy(occupancy), .err_bid(err_bid), .err_awlen(err_awlen)
  );

  int checks = 0;
  int errors = 0;
  int b_count = 0;

  // Reference model state.
  beat_t              pool[$];
  logic [1:0]         exp_b[$];
  logic [1:0]         plan_q[$];
  logic [ID_BITS-1:0] model_head = '0;

  // Controls that the main sequence sets and the engine process reads.
  logic                 engine_en = 1'b0;
  logic                 rand_mode = 1'b0;
  logic                 bready_fixed = 1'b1;
  logic                 force_valid = 1'b0;
  logic [ID_BITS-1:0]   force_id = '0;
  logic [1:0]           force_resp = '0;
  logic [ADDR_BITS-1:0] drv_addr = '0;
  logic [7:0]           drv_len = '0;

  logic       stall_prev = 1'b0;
  logic [1:0] prev_bresp = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Severity order of AXI response codes: DECERR > SLVERR > OKAY. EXOKAY counts as OKAY.
  function automatic logic [1:0] worse(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] sa;
    logic [1:0] sb;
    sa = (a == 2'd1) ? 2'd0 : a;
    sb = (b == 2'd1) ? 2'd0 : b;
    return (sa > sb) ? sa : sb;
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Downstream engine and random ready generation, driven 2 time units after each edge.
  always @(posedge aclk) begin
    int idx;
    #2;
    bus.m_awready = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    bus.s_bready  = rand_mode ? ($urandom_range(0, 2) != 0) : bready_fixed;
    if (force_valid) begin
      bus.m_bvalid = 1'b1;
      bus.m_bid    = force_id;
      bus.m_bresp  = force_resp;
    end else if (engine_en && pool.size() > 0 && $urandom_range(0, 1) == 1) begin
      idx = $urandom_range(0, pool.size() - 1);
      bus.m_bvalid = 1'b1;
      bus.m_bid    = pool[idx].id;
      bus.m_bresp  = pool[idx].resp;
      pool.delete(idx);
    end else begin
      bus.m_bvalid = 1'b0;
      bus.m_bid    = '0;
      bus.m_bresp  = 2'd0;
    end
  end

  // Monitor and scoreboard. It samples on the falling edge, and each
  // handshake it sees completes at the next rising edge.
  always @(negedge aclk) begin
    logic [1:0] r;
    logic [1:0] w;
    logic [1:0] e;
    if (!aresetn) begin
      pool.delete();
      exp_b.delete();
      model_head = '0;
      stall_prev = 1'b0;
    end else begin
      if (bus.s_awvalid && drv_len >= 8'(MAX_BURST)) begin
        check("awvalid_on_illegal", bus.m_awvalid, 1'b0);
      end
      if (bus.m_awvalid && bus.m_awready) begin
        check("m_awid", bus.m_awid, model_head);
        check("m_awaddr", bus.m_awaddr, drv_addr);
        check("m_awlen", bus.m_awlen, drv_len);
        w = 2'd0;
        for (int k = 0; k <= int'(drv_len); k++) begin
          if (plan_q.size() > 0) r = plan_q.pop_front();
          else r = 2'($urandom_range(0, 3));
          pool.push_back('{id: model_head + ID_BITS'(k), resp: r});
          w = worse(w, r);
        end
        exp_b.push_back(w);
        $display("AW id=%0d len=%0d addr=%0h expect bresp=%0d", model_head, drv_len, drv_addr, w);
        model_head = model_head + ID_BITS'(drv_len + 8'd1);
      end
      if (stall_prev) begin
        check("b_hold", {bus.s_bvalid, bus.s_bresp}, {1'b1, prev_bresp});
      end
      if (bus.s_bvalid && bus.s_bready) begin
        check("b_expected_pending", exp_b.size() > 0, 1'b1);
        if (exp_b.size() > 0) begin
          e = exp_b.pop_front();
          check("s_bresp", bus.s_bresp, e);
          $display("B #%0d bresp=%0d expected=%0d", b_count, bus.s_bresp, e);
        end
        b_count++;
      end
      stall_prev = bus.s_bvalid && !bus.s_bready;
      prev_bresp = bus.s_bresp;
    end
  end

  task automatic reset_dut();
    aresetn = 1'b0;
    tick();
    tick();
    aresetn = 1'b1;
    tick();
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    @(negedge aclk);
    while (!bus.s_awready && n < 400) begin
      @(negedge aclk);
      n++;
    end
    check("aw_accept_in_time", n < 400, 1'b1);
    tick();
    bus.s_awvalid = 1'b0;
  endtask

  task automatic start_aw(input logic [ADDR_BITS-1:0] addr, input logic [7:0] len);
    drv_addr      = addr;
    drv_len       = len;
    bus.s_awaddr  = addr;
    bus.s_awlen   = len;
    bus.s_awvalid = 1'b1;
  endtask

  task automatic send_aw(input logic [ADDR_BITS-1:0] addr, input logic [7:0] len);
    start_aw(addr, len);
    wait_accept();
  endtask

  task automatic force_b(input logic [ID_BITS-1:0] id, input logic [1:0] resp);
    force_id    = id;
    force_resp  = resp;
    force_valid = 1'b1;
    tick();
    force_valid = 1'b0;
  endtask

  // Send the pending beat for a chosen slot ID, taking its response from the model.
  task automatic deliver(input logic [ID_BITS-1:0] id);
    int  found;
    beat_t b;
    found = -1;
    for (int i = 0; i < pool.size(); i++) begin
      if (found < 0 && pool[i].id == id) found = i;
    end
    check("deliver_found", found >= 0, 1'b1);
    if (found >= 0) begin
      b = pool[found];
      pool.delete(found);
      force_b(b.id, b.resp);
    end
  endtask

  task automatic drain();
    int n;
    engine_en = 1'b1;
    n = 0;
    while ((pool.size() > 0 || exp_b.size() > 0) && n < 2000) begin
      tick();
      n++;
    end
    check("drain_in_time", n < 2000, 1'b1);
    tick();
    tick();
    engine_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start_cnt;
    logic [1:0] held;
    logic       blocked;

    bus.s_awvalid = 1'b0;
    bus.s_awaddr  = '0;
    bus.s_awlen   = '0;
    reset_dut();

    // Reset values.
    @(negedge aclk);
    check("rst_s_bvalid", bus.s_bvalid, 1'b0);
    check("rst_s_bresp", bus.s_bresp, 2'd0);
    check("rst_occupancy", occupancy, 6'd0);
    check("rst_err_bid", err_bid, 1'b0);
    check("rst_err_awlen", err_awlen, 1'b0);
    check("m_bready_const", bus.m_bready, 1'b1);
    check("rst_m_awvalid", bus.m_awvalid, 1'b0);

    // One 4-beat burst. Beats are returned out of order, and the B latency is checked.
    plan_q = '{2'd0, 2'd0, 2'd0, 2'd0};
    tick();
    send_aw(40'h12_3456_7000, 8'd3);
    deliver(5'd3);
    deliver(5'd1);
    deliver(5'd0);
    deliver(5'd2);
    @(negedge aclk);
    check("b_not_early", bus.s_bvalid, 1'b0);
    @(negedge aclk);
    check("b_latency", bus.s_bvalid, 1'b1);
    tick();
    tick();
    @(negedge aclk);
    check("t1_occupancy_zero", occupancy, 6'd0);
    check("t1_scoreboard_empty", exp_b.size(), 0);

    // Two bursts with the younger one completed first. The Bs must come back in order.
    reset_dut();
    plan_q = '{2'd2, 2'd0, 2'd3};
    send_aw(40'h100, 8'd1);
    send_aw(40'h200, 8'd0);
    deliver(5'd2);
    deliver(5'd1);
    @(negedge aclk);
    check("t2_no_b_yet", bus.s_bvalid, 1'b0);
    tick();
    deliver(5'd0);
    @(negedge aclk);
    #1;
    start_cnt = b_count;
    @(negedge aclk);
    check("t2_b0_valid", bus.s_bvalid, 1'b1);
    @(negedge aclk);
    check("t2_b1_valid_next", bus.s_bvalid, 1'b1);
    #1;
    check("t2_two_bs", b_count - start_cnt, 2);
    tick();
    tick();

    // Merge cases.
    plan_q = '{2'd0, 2'd2, 2'd3};
    send_aw(40'h300, 8'd2);
    drain();
    plan_q = '{2'd1, 2'd0, 2'd0};
    send_aw(40'h400, 8'd2);
    drain();

    // Fill all 32 slots. The ninth burst must stall until the tail burst retires.
    reset_dut();
    for (int i = 0; i < 8; i++) send_aw(40'h1000 + 40'(i * 64), 8'd3);
    @(negedge aclk);
    check("fill_occupancy", occupancy, 6'd32);
    start_aw(40'h9000, 8'd3);
    blocked = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge aclk);
      if (bus.s_awready || bus.m_awvalid) blocked = 1'b0;
    end
    check("full_blocks_aw", blocked, 1'b1);
    tick();
    deliver(5'd0);
    deliver(5'd1);
    deliver(5'd2);
    deliver(5'd3);
    wait_accept();
    drain();
    @(negedge aclk);
    check("fill_drained_occupancy", occupancy, 6'd0);

    // Backpressure with two completed bursts waiting.
    bready_fixed = 1'b0;
    send_aw(40'h5000, 8'($urandom_range(0, 3)));
    send_aw(40'h6000, 8'($urandom_range(0, 3)));
    engine_en = 1'b1;
    for (int i = 0; i < 40 && pool.size() > 0; i++) tick();
    repeat (4) tick();
    engine_en = 1'b0;
    @(negedge aclk);
    held = bus.s_bresp;
    check("bp_valid_start", bus.s_bvalid, 1'b1);
    blocked = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      if (!bus.s_bvalid || bus.s_bresp != held) blocked = 1'b0;
    end
    check("bp_held_stable", blocked, 1'b1);
    tick();
    start_cnt = b_count;
    bready_fixed = 1'b1;
    @(negedge aclk);
    #1;
    @(negedge aclk);
    #1;
    check("bp_two_consecutive", b_count - start_cnt, 2);
    tick();
    tick();

    // Error flags and reset in the middle of a burst.
    reset_dut();
    force_b(5'd7, 2'd0);
    @(negedge aclk);
    check("err_bid_unalloc", err_bid, 1'b1);
    check("err_awlen_clear", err_awlen, 1'b0);
    tick();
    send_aw(40'h7000, 8'd5);
    @(negedge aclk);
    check("err_awlen_set", err_awlen, 1'b1);
    check("illegal_no_alloc", occupancy, 6'd0);
    drv_len = 8'd0;
    tick();
    reset_dut();
    send_aw(40'h8000, 8'd3);
    deliver(5'd0);
    deliver(5'd1);
    aresetn = 1'b0;
    tick();
    @(negedge aclk);
    check("mid_rst_s_bvalid", bus.s_bvalid, 1'b0);
    check("mid_rst_s_bresp", bus.s_bresp, 2'd0);
    check("mid_rst_occupancy", occupancy, 6'd0);
    check("mid_rst_errs", {err_bid, err_awlen}, 2'b00);
    check("mid_rst_m_awvalid", bus.m_awvalid, 1'b0);
    tick();
    aresetn = 1'b1;
    tick();
    force_b(5'd2, 2'd0);
    @(negedge aclk);
    check("err_bid_after_reset", err_bid, 1'b1);
    check("stale_b_dropped", bus.s_bvalid, 1'b0);
    tick();
    reset_dut();

    // Random traffic with random readies, occasional oversize bursts and random gaps.
    rand_mode = 1'b1;
    engine_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      logic [7:0] len;
      len = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(4, 9)) : 8'($urandom_range(0, 3));
      send_aw({8'h00, 32'($urandom)}, len);
      drv_len = 8'd0;
      repeat ($urandom_range(0, 2)) tick();
    end
    drain();
    rand_mode = 1'b0;
    repeat (3) tick();
    @(negedge aclk);
    check("random_final_occupancy", occupancy, 6'd0);
    check("random_no_stray_b", err_bid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
